// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator shift register and the multiplier
// controller that reuses it: operation codes and FSM state encodings.
// -----------------------------------------------------------------------------
package acc_pkg;

  typedef logic [2:0] op_t;

  // Operation codes sampled by acc_shift_reg while it is idle.
  localparam op_t OP_HOLD     = 3'b000;
  localparam op_t OP_LOAD     = 3'b001;  // A <= adder
  localparam op_t OP_CLEAR    = 3'b010;  // A <= 0
  localparam op_t OP_ASR      = 3'b011;  // arithmetic shift right by 1
  localparam op_t OP_LSR      = 3'b100;  // logical shift right, serial_in -> MSB
  localparam op_t OP_SHL      = 3'b101;  // shift left, serial_in -> LSB
  localparam op_t OP_MASR     = 3'b110;  // multi-cycle arithmetic shift right
  localparam op_t OP_HOLD_ALT = 3'b111;

  // FSM state encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/acc_shift_reg_if.sv
// -----------------------------------------------------------------------------
// acc_shift_reg_if
// Bundles the control inputs and register outputs of acc_shift_reg.
//   op, shamt, adder, serial_in : control/data towards the register
//   A_out, serial_out           : register contents and last shifted-out bit
//   busy, done                  : multi-cycle shift status
// master modport: the controller driving the register; slave: the register.
// -----------------------------------------------------------------------------
interface acc_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
);
  import acc_pkg::*;

  op_t              op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] adder;
  logic             serial_in;
  logic [WIDTH-1:0] A_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output op, shamt, adder, serial_in,
    input  A_out, serial_out, busy, done
  );

  modport slave (
    input  op, shamt, adder, serial_in,
    output A_out, serial_out, busy, done
  );

endinterface

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Loadable down counter used to sequence multi-cycle shifts.
//   clock, reset_n : clock and asynchronous active-low reset (count -> 0)
//   load, load_val : parallel load (has priority over dec)
//   dec            : decrement by one; holds at zero
//   count          : current value
//   zero, one      : count == 0 / count == 1
// -----------------------------------------------------------------------------
module down_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
  assign one   = (cnt_q == W'(1));

endmodule

// File: rtl/acc_shift_reg.sv
// -----------------------------------------------------------------------------
// acc_shift_reg
// Accumulator register with parallel load, clear, single-cycle shifts and a
// multi-cycle arithmetic shift right by a programmable amount.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : acc_shift_reg_if.slave (op, shamt, adder, serial_in in;
//             A_out, serial_out, busy, done out)
// Ops are sampled only while idle; during a multi-cycle shift all inputs are
// ignored. done pulses for one cycle when a multi-cycle shift completes (or
// immediately for a zero shift count) and a new op may be issued in that cycle.
// -----------------------------------------------------------------------------
module acc_shift_reg
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  acc_shift_reg_if.slave bus
);

  localparam logic [31:0] WIDTH_U = WIDTH;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic             so_q;
  logic             done_q;

  logic [SHW-1:0]   sat_shamt;
  logic             start_shift;
  logic [SHW-1:0]   cnt_count;
  logic             cnt_zero;
  logic             cnt_one;

  // Shift counts beyond the register width saturate: shifting WIDTH times
  // already replicates the sign bit into every position.
  assign sat_shamt = (32'(bus.shamt) >= WIDTH_U) ? SHW'(WIDTH) : bus.shamt;

  assign start_shift = (state_q == ST_IDLE) && (bus.op == OP_MASR) &&
                       (bus.shamt != '0);

  down_counter #(.W(SHW)) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (start_shift),
    .load_val (sat_shamt),
    .dec      ((state_q == ST_SHIFT) && !cnt_zero),
    .count    (cnt_count),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          case (bus.op)
            OP_LOAD:  a_q <= bus.adder;
            OP_CLEAR: a_q <= '0;
            OP_ASR: begin
              a_q  <= {a_q[WIDTH-1], a_q[WIDTH-1:1]};
              so_q <= a_q[0];
            end
            OP_LSR: begin
              a_q  <= {bus.serial_in, a_q[WIDTH-1:1]};
              so_q <= a_q[0];
            end
            OP_SHL: begin
              a_q  <= {a_q[WIDTH-2:0], bus.serial_in};
              so_q <= a_q[WIDTH-1];
            end
            OP_MASR: begin
              // A zero count completes at once; otherwise the accepting edge
              // only arms the counter and the shifting starts next cycle.
              if (bus.shamt == '0) done_q  <= 1'b1;
              else                 state_q <= ST_SHIFT;
            end
            OP_HOLD, OP_HOLD_ALT: ;
            default: ;
          endcase
        end
        ST_SHIFT: begin
          a_q  <= {a_q[WIDTH-1], a_q[WIDTH-1:1]};
          so_q <= a_q[0];
          // cnt_zero is a safety exit; the counter is never loaded with 0.
          if (cnt_one || cnt_zero) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.A_out      = a_q;
  assign bus.serial_out = so_q;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_acc_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_acc_shift_reg
// Self-checking bench for acc_shift_reg (WIDTH=8): directed scenarios followed
// by random op streams, all compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_acc_shift_reg;
  import acc_pkg::*;

  localparam int WIDTH = 8;
  localparam int SHW   = 4;

  logic clock;
  logic reset_n;

  acc_shift_reg_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  acc_shift_reg #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: register value, last shifted-out bit, remaining
  // shifts of an ongoing multi-cycle shift, and the done pulse.
  logic [7:0] m_a;
  logic       m_so;
  int         m_rem;
  logic       m_done;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] asr1(input logic [7:0] v);
    return 8'($signed(v) >>> 1);
  endfunction

  task automatic model_reset();
    m_a = 8'h00; m_so = 1'b0; m_rem = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [3:0] sh,
                            input logic [7:0] ad, input logic si);
    m_done = 1'b0;
    if (m_rem > 0) begin
      m_so = m_a[0];
      m_a  = asr1(m_a);
      m_rem--;
      if (m_rem == 0) m_done = 1'b1;
    end else begin
      case (op)
        3'd1: m_a = ad;
        3'd2: m_a = 8'h00;
        3'd3: begin m_so = m_a[0]; m_a = asr1(m_a); end
        3'd4: begin m_so = m_a[0]; m_a = (m_a >> 1) | (8'(si) << 7); end
        3'd5: begin m_so = m_a[7]; m_a = (m_a << 1) | 8'(si); end
        3'd6: begin
          if (sh == 4'd0) m_done = 1'b1;
          else            m_rem  = (int'(sh) > 8) ? 8 : int'(sh);
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".A_out"},      32'(bus.A_out),      32'(m_a));
    check({tag, ".serial_out"}, 32'(bus.serial_out), 32'(m_so));
    check({tag, ".busy"},       32'(bus.busy),       32'(m_rem > 0));
    check({tag, ".done"},       32'(bus.done),       32'(m_done));
    check({tag, ".done_busy"},  32'(bus.done & bus.busy), 32'd0);
  endtask

  // One clock cycle: drive at the falling edge, compare 1 time unit after the
  // rising edge, return at the next falling edge.
  task automatic run(input string tag, input logic [2:0] op,
                     input logic [3:0] sh, input logic [7:0] ad,
                     input logic si);
    bus.op = op; bus.shamt = sh; bus.adder = ad; bus.serial_in = si;
    @(posedge clock);
    #1;
    model_step(op, sh, ad, si);
    check_outputs(tag);
    @(negedge clock);
  endtask

  // Run random (to-be-ignored) inputs until the model's shift finishes;
  // returns the number of cycles busy was observed high.
  task automatic run_while_busy(input string tag, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 20 && m_rem > 0; i++) begin
      if (bus.busy) busy_cycles++;
      run(tag, 3'($urandom_range(7)), 4'($urandom_range(15)),
          8'($urandom), 1'($urandom));
    end
  endtask

  int bc;

  initial begin
    reset_n = 1'b1;
    bus.op = OP_HOLD; bus.shamt = '0; bus.adder = '0; bus.serial_in = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Load then single arithmetic shift.
    run("load96", OP_LOAD, 4'd0, 8'h96, 1'b0);
    run("asr1", OP_ASR, 4'd0, 8'h00, 1'b0);
    check("asr1.value", 32'(bus.A_out), 32'h0000_00CB);

    // Multi-cycle shift by 3 from 0x96.
    run("reload96", OP_LOAD, 4'd0, 8'h96, 1'b0);
    run("masr3.accept", OP_MASR, 4'd3, 8'h00, 1'b0);
    run_while_busy("masr3", bc);
    check("masr3.busy_cycles", 32'(bc), 32'd3);
    check("masr3.value", 32'(bus.A_out), 32'h0000_00F2);

    // Logical right with fill 1, then left with fill 0.
    run("load81", OP_LOAD, 4'd0, 8'h81, 1'b0);
    run("lsr", OP_LSR, 4'd0, 8'h00, 1'b1);
    check("lsr.value", 32'(bus.A_out), 32'h0000_00C0);
    run("shl", OP_SHL, 4'd0, 8'h00, 1'b0);
    check("shl.value", 32'(bus.A_out), 32'h0000_0080);

    // Saturating shift counts.
    run("load40", OP_LOAD, 4'd0, 8'h40, 1'b0);
    run("sat15.accept", OP_MASR, 4'd15, 8'h00, 1'b0);
    run_while_busy("sat15", bc);
    check("sat15.busy_cycles", 32'(bc), 32'd8);
    check("sat15.value", 32'(bus.A_out), 32'h0000_0000);
    run("load80", OP_LOAD, 4'd0, 8'h80, 1'b0);
    run("sat8.accept", OP_MASR, 4'd8, 8'h00, 1'b0);
    run_while_busy("sat8", bc);
    check("sat8.value", 32'(bus.A_out), 32'h0000_00FF);

    // Zero-count shift: immediate done, then back-to-back load.
    run("load3c", OP_LOAD, 4'd0, 8'h3C, 1'b0);
    run("zero.accept", OP_MASR, 4'd0, 8'h00, 1'b0);
    check("zero.done", 32'(bus.done), 32'd1);
    run("zero.next", OP_LOAD, 4'd0, 8'hA5, 1'b0);

    // Load attempted during busy is ignored; op issued while done is high.
    run("busy.accept", OP_MASR, 4'd2, 8'h00, 1'b0);
    run("busy.load", OP_LOAD, 4'd0, 8'h11, 1'b0);
    run("busy.load2", OP_LOAD, 4'd0, 8'h22, 1'b0);
    run("b2b.clear", OP_CLEAR, 4'd0, 8'h00, 1'b0);
    check("b2b.value", 32'(bus.A_out), 32'd0);

    // Reset in the middle of a shift.
    run("rst.load", OP_LOAD, 4'd0, 8'hF3, 1'b0);
    run("rst.accept", OP_MASR, 4'd6, 8'h00, 1'b0);
    run("rst.shift", OP_HOLD, 4'd0, 8'h00, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst.async");
    @(posedge clock);
    #1;
    check_outputs("rst.held");
    @(negedge clock);
    reset_n = 1'b1;
    run("rst.after", OP_LOAD, 4'd0, 8'h5A, 1'b0);
    check("rst.after.value", 32'(bus.A_out), 32'h0000_005A);
    run("rst.quiet", OP_HOLD, 4'd0, 8'h00, 1'b0);

    // Random op streams against the model.
    for (int i = 0; i < 800; i++) begin
      logic [2:0] rop;
      rop = ($urandom_range(3) == 0) ? OP_MASR : 3'($urandom_range(7));
      run("rand", rop, 4'($urandom_range(15)), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
